pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline controller for the MangoMIPS32 core. It arbitrates per-stage stall requests into stall and bubble-flush masks for an NSTAGE-deep pipeline. It resolves exceptions, interrupts, TLB refills and ERET into a registered redirect that is held under a valid/ready handshake until the fetch stage accepts it. It also keeps a stall-cycle counter and a stall watchdog for debug, and sits between the pipeline stages, CP0 and the fetch unit.

## Interface
- NSTAGE, 5, number of pipeline stages; index 0 = IF, NSTAGE-1 = last stage; legal range 3..8
- ADDR_W, 32, address width
- TIMEOUT, 1024, consecutive stalled cycles before the watchdog trips; legal range 2..65535
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- stallreq  in  NSTAGE  per-stage stall request
- exc_flag  in  1  exception/ERET committed this cycle
- exc_is_intr  in  1  class qualifier: interrupt
- exc_is_tlbr  in  1  class qualifier: TLB refill
- exc_is_eret  in  1  class qualifier: ERET
- cp0_bev, cp0_exl, cp0_erl, cp0_iv  in  1 each  CP0 Status.BEV/EXL/ERL, Cause.IV
- cp0_ebase  in  ADDR_W  exception base when BEV=0
- cp0_epc, cp0_errorepc  in  ADDR_W  return addresses
- redir_ready  in  1  fetch accepts the redirect
- stall  out  NSTAGE  stage hold mask
- flush  out  NSTAGE  stage clear mask
- redir_valid  out  1  redirect pending
- redir_pc  out  ADDR_W  redirect target
- stall_cycles  out  32  count of cycles with stall != 0
- stall_timeout  out  1  sticky watchdog flag

## Operation
- Reset values: stall=0, flush=0, redir_valid=0, redir_pc=0, stall_cycles=0, stall_timeout=0, watchdog count=0.
- Stall arbitration, combinational, when exc_flag=0:
  - k = max(index of highest set stallreq bit, 1).
  - stall = bits 0..k set.
  - flush = bit k+1 only, or 0 when k = NSTAGE-1.
  - If stallreq=0, then stall=0 and flush=0.
- Exception, when exc_flag=1:
  - Same cycle: flush = all ones, stall = 0.
  - Target is computed and registered into redir_pc; redir_valid is set on the next edge.
- Qualifier priority: eret > tlbr > intr > general.
- Targets:
  - base = cp0_bev ? 0xBFC00200 : cp0_ebase.
  - eret: cp0_erl ? cp0_errorepc : cp0_epc.
  - tlbr: base + (cp0_exl ? 0x180 : 0x000).
  - intr: base + (cp0_iv ? 0x200 : 0x180).
  - general: base + 0x180.
  - Sums are ADDR_W wide, modulo 2^ADDR_W.
- Redirect handshake:
  - redir_valid stays high with redir_pc stable until a cycle with redir_ready=1, then clears on that edge.
  - While redir_valid=1 and exc_flag=0: stall[0] is forced to 1, OR'd with the arbitrated mask.
- Simultaneous events:
  - A new exc_flag while redir_valid=1 overwrites redir_pc; redir_valid stays 1. This holds even if redir_ready=1 in the same cycle, because the new target wins.
  - exc_flag overrides all stallreq.
- Counters:
  - stall_cycles increments on every edge where stall != 0, wrapping at 2^32.
  - Watchdog count increments on each stalled cycle and clears on any cycle with stall=0.
  - When the watchdog count reaches TIMEOUT, stall_timeout is set and stays set until rst.
- Reset asserted mid-redirect or mid-stall clears all state immediately, asynchronously.

## Timing
- stall and flush: combinational from inputs and redir_valid, zero latency.
- redir_valid and redir_pc: one cycle after exc_flag. The earliest acceptance edge is T+1 when redir_ready=1 in that cycle.
- Counters update on the edge that ends the stalled cycle. stall_timeout rises on the edge where the count becomes TIMEOUT, i.e. after TIMEOUT consecutive stalled cycles.
- No combinational path from redir_ready to redir_pc.

## Test plan
- Arbitration, NSTAGE=5, redir_valid=0:
  - stallreq=00001 -> stall=00011, flush=00100.
  - stallreq=00110 -> stall=00111, flush=01000.
  - stallreq=10000 -> stall=11111, flush=00000.
  - stallreq=00000 -> stall=00000, flush=00000.
- Vectors:
  - bev=0, ebase=0x80000000, general -> redir_pc=0x80000180.
  - intr with iv=1 -> 0x80000200.
  - tlbr with exl=0 -> 0x80000000.
  - bev=1, intr with iv=1 -> 0xBFC00400.
- ERET: erl=0, epc=0x80001234 -> 0x80001234. erl=1, errorepc=0xBFC00000 -> 0xBFC00000. Each with flush=11111 in the exc_flag cycle.
- Handshake: hold redir_ready=0 for 3 cycles after exc_flag -> redir_valid high 3 cycles, redir_pc stable, stall[0]=1. redir_ready=1 -> redir_valid clears next edge. Second exc_flag while pending -> redir_pc updates to the new target.
- Watchdog: TIMEOUT=4, stallreq=00100 held 3 cycles then dropped -> no trip. Then held 4 cycles -> stall_timeout=1 and stays 1 after stallreq clears. stall_cycles=7.
- Async reset mid-redirect -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall/flush arbitration, exception redirect with a
// valid/ready handoff to fetch, and stall-cycle counter plus sticky watchdog.
module pipe_ctrl #(
    parameter int NSTAGE  = 5,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq,
    input  logic              exc_flag,
    input  logic              exc_is_intr,
    input  logic              exc_is_tlbr,
    input  logic              exc_is_eret,
    input  logic              cp0_bev,
    input  logic              cp0_exl,
    input  logic              cp0_erl,
    input  logic              cp0_iv,
    input  logic [ADDR_W-1:0] cp0_ebase,
    input  logic [ADDR_W-1:0] cp0_epc,
    input  logic [ADDR_W-1:0] cp0_errorepc,
    input  logic              redir_ready,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              redir_valid,
    output logic [ADDR_W-1:0] redir_pc,
    output logic [31:0]       stall_cycles,
    output logic              stall_timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] BEV_BASE = ADDR_W'(32'hBFC0_0200);
    localparam logic [ADDR_W-1:0] OFF_180  = ADDR_W'(12'h180);
    localparam logic [ADDR_W-1:0] OFF_200  = ADDR_W'(12'h200);

    logic [NSTAGE-1:0] arb_stall;
    logic [NSTAGE-1:0] arb_flush;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] target;
    logic [WD_W-1:0]   wd_cnt;

    // A stage stalls when it or any younger-indexed-above stage requests a
    // stall; stages 0 and 1 always stall together, so the hold point is >= 1.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        logic acc;
        acc       = 1'b0;
        arb_stall = '0;
        arb_flush = '0;
        for (int i = NSTAGE - 1; i >= 2; i--) begin
            acc          = acc | stallreq[i];
            arb_stall[i] = acc;
        end
        arb_stall[1] = |stallreq;
        arb_stall[0] = |stallreq;
        // The bubble goes into the first stage above the held block.
        for (int i = 2; i < NSTAGE; i++) begin
            arb_flush[i] = arb_stall[i-1] & ~arb_stall[i];
        end
    end

    always_comb begin
        stall = '0;
        flush = '0;
        if (exc_flag) begin
            flush = '1;
        end else begin
            stall    = arb_stall;
            flush    = arb_flush;
            stall[0] = arb_stall[0] | redir_valid;
        end
    end

    // Priority: ERET, then TLB refill, then interrupt, then general exception.
    always_comb begin
        base   = cp0_bev ? BEV_BASE : cp0_ebase;
        target = base + OFF_180;
        if (exc_is_eret) begin
            target = cp0_erl ? cp0_errorepc : cp0_epc;
        end else if (exc_is_tlbr) begin
            target = base + (cp0_exl ? OFF_180 : '0);
        end else if (exc_is_intr) begin
            target = base + (cp0_iv ? OFF_200 : OFF_180);
        end
    end

    // A new exception always wins over acceptance of the pending redirect.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_valid <= 1'b0;
            redir_pc    <= '0;
        end else if (exc_flag) begin
            redir_valid <= 1'b1;
            redir_pc    <= target;
        end else if (redir_ready) begin
            redir_valid <= 1'b0;
        end
    end

    // Watchdog count saturates at TIMEOUT; the timeout flag is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles  <= '0;
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
        end else if (|stall) begin
            stall_cycles <= stall_cycles + 32'd1;
            if (wd_cnt != WD_W'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                stall_timeout <= 1'b1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the controller.
module tb_pipe_ctrl;

    localparam int N  = 5;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  stallreq;
    logic          exc_flag, exc_is_intr, exc_is_tlbr, exc_is_eret;
    logic          cp0_bev, cp0_exl, cp0_erl, cp0_iv;
    logic [AW-1:0] cp0_ebase, cp0_epc, cp0_errorepc;
    logic          redir_ready;
    logic [N-1:0]  stall, flush;
    logic          redir_valid;
    logic [AW-1:0] redir_pc;
    logic [31:0]   stall_cycles;
    logic          stall_timeout;

    int vectors;
    int miscompares;

    // Reference model state
    logic          m_valid;
    logic [AW-1:0] m_pc;
    logic [31:0]   m_cycles;
    int            m_wd;
    logic          m_to;

    pipe_ctrl #(.NSTAGE(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .stallreq(stallreq), .exc_flag(exc_flag),
        .exc_is_intr(exc_is_intr), .exc_is_tlbr(exc_is_tlbr), .exc_is_eret(exc_is_eret),
        .cp0_bev(cp0_bev), .cp0_exl(cp0_exl), .cp0_erl(cp0_erl), .cp0_iv(cp0_iv),
        .cp0_ebase(cp0_ebase), .cp0_epc(cp0_epc), .cp0_errorepc(cp0_errorepc),
        .redir_ready(redir_ready), .stall(stall), .flush(flush),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_high();
        int h = -1;
        for (int i = 0; i < N; i++) if (stallreq[i]) h = i;
        return h;
    endfunction

    function automatic logic [N-1:0] m_stall();
        logic [N-1:0] s = '0;
        int h = m_high();
        int k;
        if (exc_flag) return '0;
        if (h >= 0) begin
            k = (h < 1) ? 1 : h;
            s = N'((1 << (k + 1)) - 1);
        end
        if (m_valid) s[0] = 1'b1;
        return s;
    endfunction

    function automatic logic [N-1:0] m_flush();
        int h = m_high();
        int k;
        if (exc_flag) return '1;
        if (h < 0) return '0;
        k = (h < 1) ? 1 : h;
        if (k == N - 1) return '0;
        return N'(1 << (k + 1));
    endfunction

    function automatic logic [AW-1:0] m_target();
        logic [AW-1:0] b = cp0_bev ? 32'hBFC0_0200 : cp0_ebase;
        if (exc_is_eret) return cp0_erl ? cp0_errorepc : cp0_epc;
        if (exc_is_tlbr) return b + (cp0_exl ? 32'h180 : 32'h0);
        if (exc_is_intr) return b + (cp0_iv ? 32'h200 : 32'h180);
        return b + 32'h180;
    endfunction

    function automatic void model_edge();
        logic [N-1:0] s = m_stall();
        if (exc_flag) begin
            m_valid = 1'b1;
            m_pc    = m_target();
        end else if (redir_ready) begin
            m_valid = 1'b0;
        end
        if (s != '0) begin
            m_cycles = m_cycles + 32'd1;
            m_wd++;
            if (m_wd >= TO) m_to = 1'b1;
        end else begin
            m_wd = 0;
        end
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0; m_pc = '0; m_cycles = '0; m_wd = 0; m_to = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        stallreq = '0; exc_flag = 0; exc_is_intr = 0; exc_is_tlbr = 0; exc_is_eret = 0;
        cp0_bev = 0; cp0_exl = 0; cp0_erl = 0; cp0_iv = 0;
        cp0_ebase = 32'h8000_0000; cp0_epc = '0; cp0_errorepc = '0; redir_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 6;
        if (stall !== '0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall); end
        if (flush !== '0) begin miscompares++; $display("FAIL reset_flush: got %b want 0", flush); end
        if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", redir_valid); end
        if (redir_pc !== '0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", redir_pc); end
        if (stall_cycles !== '0) begin miscompares++; $display("FAIL reset_cycles: got %0d want 0", stall_cycles); end
        if (stall_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", stall_timeout); end
    endtask

    task automatic test_arbitration();
        logic [N-1:0] req [4] = '{5'b00001, 5'b00110, 5'b10000, 5'b00000};
        logic [N-1:0] es  [4] = '{5'b00011, 5'b00111, 5'b11111, 5'b00000};
        logic [N-1:0] ef  [4] = '{5'b00100, 5'b01000, 5'b00000, 5'b00000};
        for (int i = 0; i < 4; i++) begin
            stallreq = req[i];
            #1;
            vectors += 2;
            if (stall !== es[i]) begin miscompares++; $display("FAIL arb_stall[%0d]: got %b want %b", i, stall, es[i]); end
            if (flush !== ef[i]) begin miscompares++; $display("FAIL arb_flush[%0d]: got %b want %b", i, flush, ef[i]); end
        end
        stallreq = '0;
    endtask

    // One exception through the full handshake with an expected target constant.
    task automatic run_vector(input string name, input logic intr, input logic tlbr,
                              input logic eret, input logic bev, input logic exl,
                              input logic erl, input logic iv, input logic [AW-1:0] exp);
        exc_is_intr = intr; exc_is_tlbr = tlbr; exc_is_eret = eret;
        cp0_bev = bev; cp0_exl = exl; cp0_erl = erl; cp0_iv = iv;
        cp0_ebase = 32'h8000_0000; cp0_epc = 32'h8000_1234; cp0_errorepc = 32'hBFC0_0000;
        stallreq = N'($urandom);
        exc_flag = 1'b1; redir_ready = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (flush !== 5'b11111) begin miscompares++; $display("FAIL %s_flush: got %b want 11111", name, flush); end
        if (stall !== '0) begin miscompares++; $display("FAIL %s_stall: got %b want 0", name, stall); end
        tick();
        exc_flag = 1'b0; redir_ready = 1'b1; stallreq = '0;
        @(negedge clk);
        vectors += 3;
        if (redir_valid !== 1'b1) begin miscompares++; $display("FAIL %s_valid: got %b want 1", name, redir_valid); end
        if (redir_pc !== exp) begin miscompares++; $display("FAIL %s_pc: got %h want %h", name, redir_pc, exp); end
        if (stall !== 5'b00001) begin miscompares++; $display("FAIL %s_hold: got %b want 00001", name, stall); end
        tick();
        redir_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL %s_accept: got %b want 0", name, redir_valid); end
        tick();
    endtask

    task automatic test_vectors();
        run_vector("general",  0, 0, 0, 0, 0, 0, 0, 32'h8000_0180);
        run_vector("intr_iv",  1, 0, 0, 0, 0, 0, 1, 32'h8000_0200);
        run_vector("intr_noiv",1, 0, 0, 0, 0, 0, 0, 32'h8000_0180);
        run_vector("tlbr_exl0",0, 1, 0, 0, 0, 0, 0, 32'h8000_0000);
        run_vector("tlbr_exl1",0, 1, 0, 0, 1, 0, 0, 32'h8000_0180);
        run_vector("bev_intr", 1, 0, 0, 1, 0, 0, 1, 32'hBFC0_0400);
        run_vector("prio_tlbr",1, 1, 0, 0, 0, 0, 1, 32'h8000_0000);
    endtask

    task automatic test_eret();
        run_vector("eret_epc", 0, 0, 1, 0, 0, 0, 0, 32'h8000_1234);
        run_vector("eret_err", 0, 0, 1, 0, 0, 1, 0, 32'hBFC0_0000);
        run_vector("prio_eret",1, 1, 1, 1, 1, 0, 1, 32'h8000_1234);
    endtask

    task automatic test_handshake();
        clear_inputs();
        exc_flag = 1'b1;
        tick();
        exc_flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors += 3;
            if (redir_valid !== 1'b1) begin miscompares++; $display("FAIL hs_valid[%0d]: got %b want 1", i, redir_valid); end
            if (redir_pc !== 32'h8000_0180) begin miscompares++; $display("FAIL hs_pc[%0d]: got %h want 80000180", i, redir_pc); end
            if (stall[0] !== 1'b1) begin miscompares++; $display("FAIL hs_stall0[%0d]: got %b want 1", i, stall[0]); end
            tick();
        end
        stallreq = 5'b01000;
        @(negedge clk);
        vectors++;
        if (stall !== 5'b01111) begin miscompares++; $display("FAIL hs_or_stall: got %b want 01111", stall); end
        stallreq = '0;
        tick();
        // New exception while pending, with ready high in the same cycle.
        exc_flag = 1'b1; exc_is_intr = 1'b1; cp0_iv = 1'b1; redir_ready = 1'b1;
        tick();
        exc_flag = 1'b0; redir_ready = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (redir_valid !== 1'b1) begin miscompares++; $display("FAIL hs_overwrite_valid: got %b want 1", redir_valid); end
        if (redir_pc !== 32'h8000_0200) begin miscompares++; $display("FAIL hs_overwrite_pc: got %h want 80000200", redir_pc); end
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL hs_clear: got %b want 0", redir_valid); end
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        stallreq = 5'b00100;
        repeat (3) tick();
        stallreq = '0;
        tick();
        vectors++;
        if (stall_timeout !== 1'b0) begin miscompares++; $display("FAIL wd_no_trip: got %b want 0", stall_timeout); end
        stallreq = 5'b00100;
        repeat (3) tick();
        vectors++;
        if (stall_timeout !== 1'b0) begin miscompares++; $display("FAIL wd_early: got %b want 0", stall_timeout); end
        tick();
        vectors++;
        if (stall_timeout !== 1'b1) begin miscompares++; $display("FAIL wd_trip: got %b want 1", stall_timeout); end
        stallreq = '0;
        repeat (2) tick();
        vectors += 2;
        if (stall_timeout !== 1'b1) begin miscompares++; $display("FAIL wd_sticky: got %b want 1", stall_timeout); end
        if (stall_cycles !== 32'd7) begin miscompares++; $display("FAIL wd_cycles: got %0d want 7", stall_cycles); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            stallreq     = ($urandom_range(0, 9) < 4) ? '0 : N'($urandom);
            exc_flag     = ($urandom_range(0, 7) == 0);
            exc_is_intr  = 1'($urandom); exc_is_tlbr = 1'($urandom); exc_is_eret = 1'($urandom);
            cp0_bev      = 1'($urandom); cp0_exl = 1'($urandom);
            cp0_erl      = 1'($urandom); cp0_iv  = 1'($urandom);
            cp0_ebase    = $urandom; cp0_epc = $urandom; cp0_errorepc = $urandom;
            redir_ready  = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            vectors += 6;
            if (stall !== m_stall()) begin miscompares++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall, m_stall()); end
            if (flush !== m_flush()) begin miscompares++; $display("FAIL rnd_flush c%0d: got %b want %b", c, flush, m_flush()); end
            if (redir_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid c%0d: got %b want %b", c, redir_valid, m_valid); end
            if (redir_pc !== m_pc) begin miscompares++; $display("FAIL rnd_pc c%0d: got %h want %h", c, redir_pc, m_pc); end
            if (stall_cycles !== m_cycles) begin miscompares++; $display("FAIL rnd_cycles c%0d: got %0d want %0d", c, stall_cycles, m_cycles); end
            if (stall_timeout !== m_to) begin miscompares++; $display("FAIL rnd_timeout c%0d: got %b want %b", c, stall_timeout, m_to); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        stallreq = 5'b00010;
        exc_flag = 1'b1;
        tick();
        exc_flag = 1'b0;
        tick();
        vectors++;
        if (redir_valid !== 1'b1) begin miscompares++; $display("FAIL ar_pending: got %b want 1", redir_valid); end
        stallreq = '0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        vectors += 6;
        if (stall !== '0) begin miscompares++; $display("FAIL ar_stall: got %b want 0", stall); end
        if (flush !== '0) begin miscompares++; $display("FAIL ar_flush: got %b want 0", flush); end
        if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL ar_valid: got %b want 0", redir_valid); end
        if (redir_pc !== '0) begin miscompares++; $display("FAIL ar_pc: got %h want 0", redir_pc); end
        if (stall_cycles !== '0) begin miscompares++; $display("FAIL ar_cycles: got %0d want 0", stall_cycles); end
        if (stall_timeout !== 1'b0) begin miscompares++; $display("FAIL ar_timeout: got %b want 0", stall_timeout); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_arbitration();
        test_vectors();
        test_eret();
        test_handshake();
        test_watchdog();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
